// File: rtl/m_axi_rd_arb_pkg.sv
// rtl/m_axi_rd_arb_pkg.sv - shared state type and default parameters for the AXI read arbiter
package m_axi_rd_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_MAX_OUTST  = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Index width that stays legal for a single-entry space.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_axi_rd_arbiter_order_fifo.sv
// rtl/m_axi_rd_arbiter_order_fifo.sv - grant-order FIFO steering read responses back to requesters
module m_axi_rd_arbiter_order_fifo
    import m_axi_rd_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = DEF_MAX_OUTST
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/m_axi_rd_arbiter.sv
// rtl/m_axi_rd_arbiter.sv - round-robin AXI read-address arbiter with in-order response routing
// Optional perf counters: define M_AXI_RD_ARB_PERF_EN.
module m_axi_rd_arbiter
    import m_axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int MAX_OUTST  = DEF_MAX_OUTST
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic                            ar_valid,
    input  logic                            ar_ready,
    output logic [ADDR_WIDTH-1:0]           ar_addr,
    output logic [LEN_WIDTH-1:0]            ar_len,
    input  logic                            r_valid,
    output logic                            r_ready,
    input  logic [DATA_WIDTH-1:0]           r_data,
    input  logic                            r_last,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last
`ifdef M_AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]                     perf_stall_cnt,
    output logic [$clog2(MAX_OUTST):0]      perf_max_outst
`endif
);

    localparam int IDXW = idx_width(NUM_REQ);
    localparam int CNTW = $clog2(MAX_OUTST) + 1;

    arb_state_e             state_q;
    logic [IDXW-1:0]        grant_q;
    logic [IDXW-1:0]        rr_ptr_q;
    logic [IDXW-1:0]        rr_ptr_d;
    logic                   ar_valid_q;
    logic [ADDR_WIDTH-1:0]  ar_addr_q;
    logic [LEN_WIDTH-1:0]   ar_len_q;

    logic                   found_hi;
    logic                   found_lo;
    logic [IDXW-1:0]        idx_hi;
    logic [IDXW-1:0]        idx_lo;
    logic                   grant_found;
    logic [IDXW-1:0]        grant_d;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;

    logic                   ar_hs;
    logic                   fifo_pop;
    logic [IDXW-1:0]        fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
`ifdef M_AXI_RD_ARB_PERF_EN
    logic [CNTW-1:0]        fifo_count;
`endif

    // Two-pass scan: first requesters at or above the pointer, then wrap to the lowest valid one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[k] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = IDXW'(k);
            end
            if (req_valid[k] && !found_hi && (IDXW'(k) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = IDXW'(k);
            end
        end
        grant_found = found_lo;
        grant_d     = found_hi ? idx_hi : idx_lo;
    end

    assign rr_ptr_d = (grant_d == IDXW'(NUM_REQ - 1)) ? '0 : grant_d + 1'b1;

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDXW'(k) == grant_d) begin
                sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_len[k*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
        end else if (clk_en) begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_found && !fifo_full) begin
                        state_q    <= ARB_HOLD;
                        grant_q    <= grant_d;
                        rr_ptr_q   <= rr_ptr_d;
                        ar_valid_q <= 1'b1;
                        ar_addr_q  <= sel_addr;
                        ar_len_q   <= sel_len;
                    end
                end
                ARB_HOLD: begin
                    if (ar_ready) begin
                        state_q    <= ARB_IDLE;
                        ar_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign ar_valid = ar_valid_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = ar_len_q;
    assign ar_hs    = (state_q == ARB_HOLD) & ar_ready & clk_en;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = ar_hs && (grant_q == IDXW'(k));
            rsp_valid[k] = !fifo_empty && r_valid && (fifo_head == IDXW'(k));
        end
    end

    // The FIFO head names the requester owning the burst currently on R.
    assign r_ready  = !fifo_empty && rsp_ready[fifo_head];
    assign rsp_data = r_data;
    assign rsp_last = r_last;
    assign fifo_pop = r_valid & r_ready & r_last;

    m_axi_rd_arbiter_order_fifo #(
        .WIDTH (IDXW),
        .DEPTH (MAX_OUTST)
    ) u_order_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (clk_en),
        .push_i      (ar_hs),
        .push_data_i (grant_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
`ifdef M_AXI_RD_ARB_PERF_EN
        .count_o     (fifo_count),
`else
        .count_o     (),
`endif
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef M_AXI_RD_ARB_PERF_EN
    logic [31:0]     stall_q;
    logic [CNTW-1:0] max_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            max_q   <= '0;
        end else if (clk_en) begin
            if (ar_valid_q && !ar_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (fifo_count > max_q) max_q <= fifo_count;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_max_outst = max_q;
`endif

endmodule

// File: tb/tb_m_axi_rd_arbiter.sv
// tb/tb_m_axi_rd_arbiter.sv - directed and randomized checks of m_axi_rd_arbiter against a queue model
module tb_m_axi_rd_arbiter;

    localparam int NR = 3;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int MO = 4;

    logic             clk;
    logic             reset;
    logic             clk_en;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic             ar_valid;
    logic             ar_ready;
    logic [AW-1:0]    ar_addr;
    logic [LW-1:0]    ar_len;
    logic             r_valid;
    logic             r_ready;
    logic [DW-1:0]    r_data;
    logic             r_last;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic             rsp_last;
`ifdef M_AXI_RD_ARB_PERF_EN
    logic [31:0]              perf_stall_cnt;
    logic [$clog2(MO):0]      perf_max_outst;
`endif

    m_axi_rd_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .MAX_OUTST  (MO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_last    (r_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last)
`ifdef M_AXI_RD_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_max_outst (perf_max_outst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: one burst may wait on AR; granted bursts queue in grant order until their r_last.
    bit            m_busy   = 1'b0;
    int            m_gidx   = 0;
    logic [AW-1:0] m_addr   = '0;
    logic [LW-1:0] m_len    = '0;
    int            m_ptr    = 0;
    int            q[$];
    longint        m_stall  = 0;
    int            m_maxocc = 0;

    always @(negedge clk) begin : cmp
        bit            ne;
        int            head;
        bit            e_rready;
        logic [NR-1:0] e_req_ready;
        logic [NR-1:0] e_rsp_valid;
        int            pre;
        bit            done;
        int            idx;

        ne          = (q.size() > 0);
        head        = ne ? q[0] : 0;
        e_rready    = ne && (((rsp_ready >> head) & NR'(1)) != '0);
        e_req_ready = (m_busy && ar_ready && clk_en) ? (NR'(1) << m_gidx) : '0;
        e_rsp_valid = (ne && r_valid) ? (NR'(1) << head) : '0;

        if (chk_on) begin
            chk("ar_valid", ar_valid, m_busy);
            chk("ar_addr", ar_addr, m_addr);
            chk("ar_len", ar_len, m_len);
            chk("req_ready", req_ready, e_req_ready);
            chk("r_ready", r_ready, e_rready);
            chk("rsp_valid", rsp_valid, e_rsp_valid);
            chk("rsp_data", rsp_data, r_data);
            chk("rsp_last", rsp_last, r_last);
`ifdef M_AXI_RD_ARB_PERF_EN
            chk("perf_stall_cnt", perf_stall_cnt, m_stall);
            chk("perf_max_outst", perf_max_outst, m_maxocc);
`endif
        end

        if (reset) begin
            m_busy = 1'b0; m_gidx = 0; m_addr = '0; m_len = '0; m_ptr = 0;
            q.delete(); m_stall = 0; m_maxocc = 0;
        end else if (clk_en) begin
            pre = q.size();
            if (m_busy && !ar_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (pre > m_maxocc) m_maxocc = pre;
            if (ne && r_valid && e_rready && r_last) void'(q.pop_front());
            if (m_busy && ar_ready) begin
                q.push_back(m_gidx);
                m_busy = 1'b0;
            end else if (!m_busy && pre < MO) begin
                done = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!done && (((req_valid >> idx) & NR'(1)) != '0)) begin
                        done   = 1'b1;
                        m_busy = 1'b1;
                        m_gidx = idx;
                        m_addr = AW'(req_addr >> (idx * AW));
                        m_len  = LW'(req_len >> (idx * LW));
                        m_ptr  = (idx + 1) % NR;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        rsp_ready = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[k*AW +: AW] = a;
        req_len[k*LW +: LW]  = l;
    endtask

    initial begin
        bit got;
        req_addr = '0;
        req_len  = '0;
        r_data   = '0;
        do_reset();
        chk_on = 1'b1;

        // Reset state with R traffic offered: nothing may be accepted or routed.
        r_valid = 1'b1; rsp_ready = '1;
        @(negedge clk);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_r_ready", r_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ar_addr", ar_addr, 0);
        tick();
        r_valid = 1'b0;

        // Single requester burst, four beats.
        set_req(0, 64'h1000, 8'd3);
        req_valid = 3'b001; ar_ready = 1'b1;
        @(negedge clk);
        chk("b1_idle_ar_valid", ar_valid, 0);
        tick();
        @(negedge clk);
        chk("b1_ar_valid", ar_valid, 1);
        chk("b1_ar_addr", ar_addr, 64'h1000);
        chk("b1_ar_len", ar_len, 3);
        chk("b1_req_ready", req_ready, 3'b001);
        tick();
        req_valid = '0; rsp_ready = '1;
        for (int b = 0; b < 4; b++) begin
            r_valid = 1'b1; r_last = (b == 3); r_data = 32'hA0 + b;
            @(negedge clk);
            chk("b1_rsp_valid", rsp_valid, 3'b001);
            chk("b1_rsp_last", rsp_last, (b == 3));
            chk("b1_rsp_data", rsp_data, 32'hA0 + b);
            tick();
        end
        r_valid = 1'b0; r_last = 1'b0;
        @(negedge clk);
        chk("b1_drained_r_ready", r_ready, 0);
        tick();

        // Two requesters held valid: grants alternate, AR every other cycle, then FIFO full.
        do_reset();
        set_req(0, 64'h2000, 8'd1);
        set_req(1, 64'h3000, 8'd2);
        req_valid = 3'b011; ar_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("alt_ar_valid", ar_valid, c % 2);
            chk("alt_req_ready", req_ready, (c % 2 == 1) ? (3'b001 << ((c / 2) % 2)) : 3'b000);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("full_no_grant", ar_valid, 0);
            tick();
        end
        r_valid = 1'b1; r_last = 1'b1; rsp_ready = '1;
        @(negedge clk);
        chk("full_pop_rsp_valid", rsp_valid, 3'b001);
        chk("full_pop_r_ready", r_ready, 1);
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            r_valid = 1'b0; r_last = 1'b0;
            @(negedge clk);
            if (ar_valid && !got) begin
                got = 1'b1;
                chk("after_pop_grant_idx", req_ready, 3'b001);
            end
        end
        chk("after_pop_grant_within_2", got, 1);
        tick();

        // AR stalled five cycles: address held while the requester changes its inputs.
        do_reset();
        set_req(0, 64'hABCD_0000, 8'd7);
        req_valid = 3'b001; ar_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            set_req(0, {$urandom, $urandom}, 8'($urandom));
            @(negedge clk);
            chk("stall_ar_valid", ar_valid, 1);
            chk("stall_ar_addr", ar_addr, 64'hABCD_0000);
            chk("stall_ar_len", ar_len, 7);
            chk("stall_req_ready", req_ready, 0);
            tick();
        end
        ar_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_req_ready", req_ready, 3'b001);
`ifdef M_AXI_RD_ARB_PERF_EN
        chk("stall_perf_cnt", perf_stall_cnt, 5);
`endif
        tick();
        req_valid = '0;

        // Requester 1 back-pressures its response.
        do_reset();
        req_valid = 3'b010; ar_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_req_ready", req_ready, 3'b010);
        tick();
        req_valid = '0; r_valid = 1'b1; r_last = 1'b0; rsp_ready = 3'b101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_r_ready_low", r_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 3'b010);
            tick();
        end
        rsp_ready = 3'b111;
        @(negedge clk);
        chk("bp_r_ready_high", r_ready, 1);
        tick();
        r_valid = 1'b0;

        // Reset with two outstanding bursts discards them and restarts the pointer.
        do_reset();
        req_valid = 3'b010; ar_ready = 1'b1;
        repeat (4) tick();
        req_valid = '0;
        do_reset();
        r_valid = 1'b1; rsp_ready = '1;
        @(negedge clk);
        chk("rst2_r_ready", r_ready, 0);
        chk("rst2_rsp_valid", rsp_valid, 0);
        tick();
        r_valid = 1'b0; req_valid = 3'b111; ar_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("rst2_first_grant", req_ready, 3'b001);
        tick();

        // Randomized traffic, including clock-enable gaps and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            clk_en    = ($urandom_range(0, 7) != 0);
            req_valid = NR'($urandom);
            for (int k = 0; k < NR; k++) set_req(k, {$urandom, $urandom}, 8'($urandom));
            ar_ready  = ($urandom_range(0, 2) != 0);
            r_valid   = $urandom_range(0, 1) != 0;
            r_last    = ($urandom_range(0, 2) == 0);
            r_data    = $urandom;
            rsp_ready = NR'($urandom);
            tick();
        end
        reset = 1'b0; clk_en = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_axi_rd_arbiter.md
M_AXI_RD_ARBITER -- requirements
Module: m_axi_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of read requesters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 64: AXI address width.
REQ-003 Parameter DATA_WIDTH, default 32: read data width.
REQ-004 Parameter LEN_WIDTH, default 8: burst length field width (beats-1 encoding).
REQ-005 Parameter MAX_OUTST, default 4: maximum outstanding bursts (power of 2).
REQ-006 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-007 clk_en  in  1  global clock enable; all state updates gated by it.
REQ-008 req_valid  in  NUM_REQ; req_ready  out  NUM_REQ; per-requester burst request handshake.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH; req_len  in  NUM_REQ*LEN_WIDTH; packed per requester, requester 0 at LSBs.
REQ-010 ar_valid  out  1; ar_ready  in  1; ar_addr  out  ADDR_WIDTH; ar_len  out  LEN_WIDTH; master read-address channel.
REQ-011 r_valid  in  1; r_ready  out  1; r_data  in  DATA_WIDTH; r_last  in  1; master read-data channel.
REQ-012 rsp_valid  out  NUM_REQ; rsp_ready  in  NUM_REQ; rsp_data  out  DATA_WIDTH (shared); rsp_last  out  1 (shared).

Function
REQ-013 Arbiter FSM SHALL have states IDLE and HOLD.
REQ-014 In IDLE, if any req_valid is high and the order FIFO is not full, the arbiter SHALL grant one requester round-robin and enter HOLD on the next cycle.
REQ-015 Round-robin search SHALL start at the index after the last granted requester, wrapping NUM_REQ-1 to 0; the pointer starts at 0.
REQ-016 In HOLD, ar_valid SHALL be 1 with ar_addr/ar_len registered from the granted requester and held stable until ar_ready.
REQ-017 On the AR handshake (HOLD & ar_valid & ar_ready), req_ready of the granted requester SHALL be 1 for that cycle only, the grant index SHALL be pushed to the order FIFO, and FSM SHALL return to IDLE.
REQ-018 Request-to-ar_valid latency SHALL be 1 cycle; sustained throughput SHALL be one burst per 2 cycles.
REQ-019 req_ready SHALL be 0 for all requesters outside the AR handshake cycle.
REQ-020 r_ready SHALL equal rsp_ready[head] when the order FIFO is non-empty, else 0.
REQ-021 rsp_valid[head] SHALL equal r_valid when the order FIFO is non-empty; other rsp_valid bits SHALL be 0; rsp_data/rsp_last SHALL pass through r_data/r_last combinationally.
REQ-022 Order FIFO SHALL pop on r_valid & r_ready & r_last.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, including when full; a push while full cannot occur (REQ-014).
REQ-024 With the order FIFO full, no new grant SHALL be issued; a burst already in HOLD SHALL complete.
REQ-025 r_valid while the order FIFO is empty SHALL be ignored (r_ready 0).
REQ-026 With clk_en low, FSM, pointer and FIFO SHALL hold; combinational outputs follow current state.

Reset
REQ-027 On reset: FSM IDLE, RR pointer 0, order FIFO empty, ar_valid 0, req_ready 0, r_ready 0, rsp_valid 0, ar_addr/ar_len 0.
REQ-028 Reset mid-burst SHALL discard all outstanding order entries; no response routing resumes for them.

Configuration
REQ-029 Macro M_AXI_RD_ARB_PERF_EN defined: adds outputs perf_stall_cnt (32 bits, counts cycles with ar_valid & ~ar_ready, saturating) and perf_max_outst (log2(MAX_OUTST)+1 bits, peak FIFO occupancy); both cleared by reset.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package m_axi_rd_arb_pkg SHALL hold FSM state enum and the default parameter constants.
REQ-032 The order FIFO SHALL be sub-module m_axi_rd_arbiter_order_fifo (width clog2(NUM_REQ), depth MAX_OUTST, registered count, full/empty flags).

Verification
REQ-033 Req0 only, addr 0x1000 len 3, ar_ready 1 -> ar_valid cycle 1, ar_addr 0x1000 ar_len 3, req_ready[0] pulse, 4 beats routed to rsp_valid[0], rsp_last on beat 4.
REQ-034 Req0 and req1 held valid continuously -> grants alternate 0,1,0,1; ar_valid every 2nd cycle.
REQ-035 ar_ready low 5 cycles in HOLD -> ar_addr/ar_len stable 5 cycles, no req_ready; perf_stall_cnt = 5 when PERF_EN.
REQ-036 4 bursts granted, no R data -> FIFO full, 5th request not granted; one r_last pop -> grant within 2 cycles.
REQ-037 rsp_ready[1] low while head is requester 1 with r_valid high -> r_ready 0, beat held; rsp_ready[1] high -> beat transferred.
REQ-038 Reset asserted with 2 outstanding bursts -> FIFO empty, r_ready 0, next grant starts search from requester 0.
